// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with an internal baud divider and a
// valid/ready input handshake. Frame: start bit, DATA_BITS data bits (LSB
// first), optional parity bit, STOP_BITS stop bits. All outputs are registered.
// Optional break generation is built only when UART_TX_BREAK_EN is defined.
module uart_tx_cfg #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clkIN,
  input  logic                 resetIN,
  input  logic [DATA_BITS-1:0] dataIN,
  input  logic                 validIN,
  output logic                 readyOUT,
  input  logic                 breakIN,
  output logic                 txOUT,
  output logic                 busyOUT
);

  localparam int unsigned TimerW    = $clog2(CLK_DIV);
  localparam int unsigned FrameBits = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]   DataLast  = CntW'(DATA_BITS - 1);
  localparam logic [CntW-1:0]   StopLast  = CntW'(STOP_BITS - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [CntW-1:0]   FrameLast = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0]   FrameCnt  = CntW'(FrameBits);
`endif

  // Illegal configurations are flagged at elaboration.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_cfg: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
`ifdef UART_TX_BREAK_EN
    ,
    StBrk,
    StMark
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   timer_last;

`ifndef UART_TX_BREAK_EN
  // Break input has no function in this build.
  logic unused_break;
  assign unused_break = breakIN;
`endif

  assign timer_last = (timer_q == TimerLast);

  // Next-state logic; outputs are computed from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    timer_d = timer_last ? '0 : timer_q + 1'b1;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        tx_d    = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (breakIN) begin
          state_d = StBrk;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end else
`endif
        if (validIN && ready_q) begin
          state_d = StStart;
          cnt_d   = '0;
          shift_d = dataIN;
          par_d   = (PARITY == 1) ? ~(^dataIN) : ^dataIN;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (timer_last) begin
          state_d = StData;
          cnt_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (timer_last) begin
          if (cnt_q == DataLast) begin
            cnt_d = '0;
            if (PARITY != 0) begin
              state_d = StPar;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StPar: begin
        tx_d = par_q;
        if (timer_last) begin
          state_d = StStop;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (timer_last) begin
          if (cnt_q == StopLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      StBrk: begin
        tx_d = 1'b0;
        // cnt_q counts completed bit periods, saturating once a full frame has elapsed.
        if (timer_last && cnt_q != FrameCnt) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!breakIN && (cnt_q == FrameCnt || (cnt_q == FrameLast && timer_last))) begin
          state_d = StMark;
          cnt_d   = '0;
          timer_d = '0;
          tx_d    = 1'b1;
        end
      end
      StMark: begin
        tx_d = 1'b1;
        if (timer_last) begin
          if (cnt_q == StopLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = StIdle;
        timer_d = '0;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = ~ready_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign txOUT    = tx_q;
  assign readyOUT = ready_q;
  assign busyOUT  = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: three parity/stop configurations, random and
// directed frames checked by a queue-based scoreboard, plus reset and break tests.
module tb_uart_tx_cfg;

  localparam int CD      = 4;
  localparam int DB      = 8;
  localparam int NCFG    = 3;
  localparam int NFRAMES = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          b2b;
  } exp_t;

  exp_t sbq[NCFG][$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_done[NCFG];
  bit   mon_en[NCFG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: line level for each bit period, in transmission order.
  function automatic exp_t model(input int par, input int stop, input logic [7:0] d,
                                 input bit b2b);
    exp_t e;
    int   k;
    int   ones;
    e.bits = '0;
    k = 0;
    e.bits[k] = 1'b0;
    k++;
    for (int i = 0; i < DB; i++) begin
      e.bits[k] = d[i];
      k++;
    end
    if (par != 0) begin
      ones = $countones(d);
      e.bits[k] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      k++;
    end
    for (int s = 0; s < stop; s++) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.n   = k;
    e.b2b = b2b;
    return e;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int STP = (g == 2) ? 2 : 1;
    localparam int FL  = (1 + DB + ((PAR != 0) ? 1 : 0) + STP) * CD;

    logic          rst;
    logic          valid;
    logic          ready;
    logic          brk;
    logic          tx;
    logic          busy;
    logic [DB-1:0] data;

    uart_tx_cfg #(
      .CLK_DIV  (CD),
      .DATA_BITS(DB),
      .PARITY   (PAR),
      .STOP_BITS(STP)
    ) u_dut (
      .clkIN   (clk),
      .resetIN (rst),
      .dataIN  (data),
      .validIN (valid),
      .readyOUT(ready),
      .breakIN (brk),
      .txOUT   (tx),
      .busyOUT (busy)
    );

    // Driver: reset, scoreboard frames, then reset-abort and break tests.
    initial begin
      logic [7:0] dir[5];
      bit         held;
      int         w;
      int         cnt;
      dir = '{8'h55, 8'h07, 8'hA5, 8'h3C, 8'h00};
      rst = 1'b1; valid = 1'b0; brk = 1'b0; data = '0;
      held = 1'b0;
      mon_en[g] = 1'b1;
      repeat (3) @(negedge clk);
      check($sformatf("cfg%0d reset_state", g), 32'({tx, ready, busy}), 32'b100);
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d ready_after_reset", g), 32'({tx, ready, busy}), 32'b110);

      for (int f = 0; f < NFRAMES; f++) begin
        data  = (f < 5) ? dir[f] : 8'($urandom);
        valid = 1'b1;
        w = 0;
        while (!ready && w < 200) begin
          @(negedge clk);
          w++;
        end
        if (!ready) begin
          check($sformatf("cfg%0d accept_timeout", g), 32'(ready), 32'd1);
        end else begin
          sbq[g].push_back(model(PAR, STP, data, held));
        end
        @(negedge clk);
        held = (f == 2) || ($urandom_range(0, 3) == 0);
        if (held) begin
          data = 8'($urandom);
        end else begin
          valid = 1'b0;
          data  = 8'($urandom);
          repeat ($urandom_range(0, 60)) @(negedge clk);
        end
      end
      valid = 1'b0;
      w = 0;
      while ((sbq[g].size() != 0 || busy) && w < 1000) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("cfg%0d drain", g), 32'(sbq[g].size()), 32'd0);
      repeat (2) @(negedge clk);
      mon_en[g] = 1'b0;

`ifdef UART_TX_BREAK_EN
      // Long break with a frame pending: break wins, low 100 cycles, then mark.
      brk = 1'b1; valid = 1'b1; data = 8'($urandom);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if ({tx, ready, busy} == 3'b001) cnt++;
      end
      check($sformatf("cfg%0d break_low", g), 32'(cnt), 32'd100);
      brk = 1'b0; valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < STP * CD; i++) begin
        @(negedge clk);
        if ({tx, ready, busy} == 3'b101) cnt++;
      end
      check($sformatf("cfg%0d break_mark", g), 32'(cnt), 32'(STP * CD));
      @(negedge clk);
      check($sformatf("cfg%0d break_idle", g), 32'({tx, ready, busy}), 32'b110);
      // One-cycle break request still lasts a full frame.
      brk = 1'b1;
      @(negedge clk);
      brk = 1'b0;
      cnt = 0;
      while (tx == 1'b0 && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      check($sformatf("cfg%0d break_min", g), 32'(cnt), 32'(FL));
      repeat (STP * CD + 2) @(negedge clk);
`else
      // Break has no effect in this build; hold it high during the next frame.
      brk = 1'b1;
`endif

      // Reset in the middle of a frame aborts it.
      data = 8'($urandom); valid = 1'b1;
      w = 0;
      while (!ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      @(negedge clk);
      valid = 1'b0;
      check($sformatf("cfg%0d abort_start_bit", g), 32'({tx, ready, busy}), 32'b001);
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check($sformatf("cfg%0d abort_reset", g), 32'({tx, ready, busy}), 32'b100);
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d abort_release", g), 32'({tx, ready, busy}), 32'b110);
      cnt = 0;
      for (int i = 0; i < 2 * FL; i++) begin
        @(negedge clk);
        if (tx != 1'b1 || busy != 1'b0) cnt++;
      end
      check($sformatf("cfg%0d no_resume", g), 32'(cnt), 32'd0);
      brk = 1'b0;
      drv_done[g] = 1'b1;
    end

    // Monitor: on each frame start pop the expected frame and compare cycle by cycle.
    initial begin
      int   idle;
      exp_t e;
      idle = 1000;
      forever begin
        @(negedge clk);
        if (mon_en[g] && busy) begin
          if (sbq[g].size() == 0) begin
            check($sformatf("cfg%0d unexpected_frame", g), 32'(busy), 32'd0);
            for (int k = 0; k < 500 && busy; k++) @(negedge clk);
            idle = 1000;
          end else begin
            e = sbq[g].pop_front();
            if (e.b2b) check($sformatf("cfg%0d b2b_gap", g), 32'(idle), 32'd1);
            for (int c = 0; c < e.n * CD; c++) begin
              if (c > 0) @(negedge clk);
              check($sformatf("cfg%0d frame_cycle%0d", g, c), 32'({tx, ready, busy}),
                    32'({e.bits[c / CD], 2'b01}));
            end
            @(negedge clk);
            check($sformatf("cfg%0d idle_after_frame", g), 32'({tx, ready, busy}), 32'b110);
            idle = 1;
          end
        end else begin
          idle++;
        end
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(drv_done[0] && drv_done[1] && drv_done[2]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60000) check("global_timeout", 32'(t), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
